// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int REGBITS_DEF = 3;

  typedef logic [REGBITS_DEF-1:0] reg_addr_t;
  typedef logic [WIDTH_DEF-1:0]   reg_data_t;

  // Address of the hardwired-zero register when that option is enabled.
  localparam reg_addr_t ZERO_ADDR = {REGBITS_DEF{1'b0}};

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: set by accepted issues, cleared by writes,
// and the issue-ready decision that lets decode stall on RAW/WAW hazards.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int REGBITS  = REGBITS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we0,
  input  logic [REGBITS-1:0]        wa0,
  input  logic                      we1,
  input  logic [REGBITS-1:0]        wa1,
  input  logic                      issue_valid,
  input  logic [REGBITS-1:0]        issue_wa,
  output logic                      issue_ready,
  output logic [(1<<REGBITS)-1:0]   pending
);

  localparam int DEPTH = 1 << REGBITS;

  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_nxt_s;
  logic             issue_zero_s;
  logic             write_hit_s;
  logic             hazard_s;
  logic             set_s;

  // Hazard on the requested destination; a same-cycle write may lift it only with bypass.
  always_comb begin
    issue_zero_s = (ZERO_REG != 0) && (issue_wa == '0);
    write_hit_s  = (we0 && (wa0 == issue_wa)) || (we1 && (wa1 == issue_wa));
    if (issue_zero_s) begin
      hazard_s = 1'b0;
    end else if (BYPASS != 0) begin
      hazard_s = pending_r[issue_wa] && !write_hit_s;
    end else begin
      hazard_s = pending_r[issue_wa];
    end
  end

  assign issue_ready = issue_valid && !hazard_s;
  assign set_s       = issue_ready && !issue_zero_s;

  // Next scoreboard state: a new producer (set) takes precedence over a retiring write (clear).
  always_comb begin
    pending_nxt_s = pending_r;
    for (int j = 0; j < DEPTH; j++) begin
      if (set_s && (issue_wa == REGBITS'(j))) begin
        pending_nxt_s[j] = 1'b1;
      end else if ((we0 && (wa0 == REGBITS'(j))) || (we1 && (wa1 == REGBITS'(j)))) begin
        pending_nxt_s[j] = 1'b0;
      end else begin
        pending_nxt_s[j] = pending_r[j];
      end
    end
    pending_nxt_s[0] = (ZERO_REG != 0) ? 1'b0 : pending_nxt_s[0];
  end

  // Scoreboard register; reset discards every in-flight producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with combinational reads, two write ports
// (port 1 has priority), optional bypass and hardwired zero, plus scoreboard.
import regfile_pkg::*;

module regfile_sb #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int REGBITS  = REGBITS_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREAD*REGBITS-1:0]  ra,
  output logic [NREAD*WIDTH-1:0]    rd,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      we0,
  input  logic [REGBITS-1:0]        wa0,
  input  logic [WIDTH-1:0]          wd0,
  input  logic                      we1,
  input  logic [REGBITS-1:0]        wa1,
  input  logic [WIDTH-1:0]          wd1,
  input  logic                      issue_valid,
  input  logic [REGBITS-1:0]        issue_wa,
  output logic                      issue_ready,
  output logic [(1<<REGBITS)-1:0]   pending
);

  localparam int DEPTH = 1 << REGBITS;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr0_ok_s;
  logic             wr1_ok_s;

  // Writes to the hardwired-zero register are dropped before they reach storage.
  assign wr0_ok_s = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok_s = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Storage update; port 1 overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_r[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (wr1_ok_s && (wa1 == REGBITS'(j))) begin
          mem_r[j] <= wd1;
        end else if (wr0_ok_s && (wa0 == REGBITS'(j))) begin
          mem_r[j] <= wd0;
        end else begin
          mem_r[j] <= mem_r[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [REGBITS-1:0] addr_s;
    logic [WIDTH-1:0]   data_s;
    logic               busy_s;
    logic               hit0_s;
    logic               hit1_s;

    assign addr_s = ra[i*REGBITS +: REGBITS];
    assign hit0_s = wr0_ok_s && (wa0 == addr_s);
    assign hit1_s = wr1_ok_s && (wa1 == addr_s);

    // Read data: zero register first, then same-cycle forwarding, then storage.
    always_comb begin
      if ((ZERO_REG != 0) && (addr_s == '0)) begin
        data_s = '0;
      end else if ((BYPASS != 0) && hit1_s) begin
        data_s = wd1;
      end else if ((BYPASS != 0) && hit0_s) begin
        data_s = wd0;
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    // Busy flag: a write landing this cycle retires the producer early when forwarding.
    always_comb begin
      if ((ZERO_REG != 0) && (addr_s == '0)) begin
        busy_s = 1'b0;
      end else if ((BYPASS != 0) && ((we0 && (wa0 == addr_s)) || (we1 && (wa1 == addr_s)))) begin
        busy_s = 1'b0;
      end else begin
        busy_s = pending[addr_s];
      end
    end

    assign rd[i*WIDTH +: WIDTH] = data_s;
    assign rbusy[i]             = busy_s;
  end

  regfile_scoreboard #(
    .REGBITS  (REGBITS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .we0         (we0),
    .wa0         (wa0),
    .we1         (we1),
    .wa1         (wa1),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .issue_ready (issue_ready),
    .pending     (pending)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized
// run against a behavioural model of the register file and scoreboard.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Bypass + zero-register instance (default parameters)
  logic [5:0]  ra;
  logic [15:0] rd;
  logic [1:0]  rbusy;
  logic        we0, we1, issue_valid, issue_ready;
  logic [2:0]  wa0, wa1, issue_wa;
  logic [7:0]  wd0, wd1, pending;

  // No-bypass instance
  logic [5:0]  n_ra;
  logic [15:0] n_rd;
  logic [1:0]  n_rbusy;
  logic        n_we0, n_we1, n_issue_valid, n_issue_ready;
  logic [2:0]  n_wa0, n_wa1, n_issue_wa;
  logic [7:0]  n_wd0, n_wd1, n_pending;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] m_mem [8];
  logic [7:0] m_pend;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_valid(issue_valid), .issue_wa(issue_wa), .issue_ready(issue_ready),
    .pending(pending)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra(n_ra), .rd(n_rd), .rbusy(n_rbusy),
    .we0(n_we0), .wa0(n_wa0), .wd0(n_wd0), .we1(n_we1), .wa1(n_wa1), .wd1(n_wd1),
    .issue_valid(n_issue_valid), .issue_wa(n_issue_wa), .issue_ready(n_issue_ready),
    .pending(n_pending)
  );

  function automatic logic [7:0] m_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic m_ready();
    if (!issue_valid) return 1'b0;
    if (issue_wa == 3'd0) return 1'b1;
    if ((we0 && wa0 == issue_wa) || (we1 && wa1 == issue_wa)) return 1'b1;
    return !m_pend[issue_wa];
  endfunction

  task automatic m_edge(input logic acc);
    if (we0 && wa0 != 3'd0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 3'd0) m_mem[wa1] = wd1;
    if (we0) m_pend[wa0] = 1'b0;
    if (we1) m_pend[wa1] = 1'b0;
    if (acc && issue_wa != 3'd0) m_pend[issue_wa] = 1'b1;
  endtask

  task automatic idle();
    ra = 6'd0; we0 = 1'b0; we1 = 1'b0; wa0 = 3'd0; wa1 = 3'd0; wd0 = 8'd0; wd1 = 8'd0;
    issue_valid = 1'b0; issue_wa = 3'd0;
    n_ra = 6'd0; n_we0 = 1'b0; n_we1 = 1'b0; n_wa0 = 3'd0; n_wa1 = 3'd0; n_wd0 = 8'd0; n_wd1 = 8'd0;
    n_issue_valid = 1'b0; n_issue_wa = 3'd0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) m_mem[j] = 8'h00;
    m_pend = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    issue_valid = 1'b1; issue_wa = 3'd3;
    #1;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h want 0000", rd); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    // preload data and a pending bit, then reset asynchronously mid-cycle
    @(negedge clk);
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 3'd3; wd0 = 8'h77;
    we1 = 1'b1; wa1 = 3'd6; wd1 = 8'h99;
    issue_valid = 1'b1; issue_wa = 3'd5;
    @(posedge clk);
    #1;
    idle();
    ra = {3'd6, 3'd3};
    #1;
    checks++; if (rd !== 16'h9977) begin errors++; $display("FAIL preload_rd got %h want 9977", rd); end
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL preload_pending got %h want 20", pending); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL async_reset_rd got %h want 0000", rd); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL async_reset_pending got %h want 00", pending); end
    we1 = 1'b1; wa1 = 3'd6; wd1 = 8'hAB;
    #1;
    checks++; if (rd[15:8] !== 8'hAB) begin errors++; $display("FAIL reset_bypass_rd got %h want ab", rd[15:8]); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_nobypass();
    pulse_reset();
    @(negedge clk);
    n_we0 = 1'b1; n_wa0 = 3'd3; n_wd0 = 8'hA5; n_ra = {3'd0, 3'd3};
    #1;
    checks++; if (n_rd[7:0] !== 8'h00) begin errors++; $display("FAIL nb_before_edge got %h want 00", n_rd[7:0]); end
    @(posedge clk);
    #1;
    checks++; if (n_rd[7:0] !== 8'hA5) begin errors++; $display("FAIL nb_after_edge got %h want a5", n_rd[7:0]); end
    // without bypass a pending bit blocks issue until the cycle after its write
    @(negedge clk);
    n_we0 = 1'b0;
    n_issue_valid = 1'b1; n_issue_wa = 3'd6;
    #1;
    checks++; if (n_issue_ready !== 1'b1) begin errors++; $display("FAIL nb_first_issue got %b want 1", n_issue_ready); end
    @(negedge clk);
    n_we0 = 1'b1; n_wa0 = 3'd6; n_wd0 = 8'h44; n_ra = {3'd0, 3'd6};
    #1;
    checks++; if (n_issue_ready !== 1'b0) begin errors++; $display("FAIL nb_write_cycle_ready got %b want 0", n_issue_ready); end
    checks++; if (n_rbusy[0] !== 1'b1) begin errors++; $display("FAIL nb_write_cycle_rbusy got %b want 1", n_rbusy[0]); end
    checks++; if (n_rd[7:0] !== 8'h00) begin errors++; $display("FAIL nb_write_cycle_rd got %h want 00", n_rd[7:0]); end
    @(posedge clk);
    #1;
    checks++; if (n_pending[6] !== 1'b0) begin errors++; $display("FAIL nb_cleared got %b want 0", n_pending[6]); end
    checks++; if (n_issue_ready !== 1'b1) begin errors++; $display("FAIL nb_next_cycle_ready got %b want 1", n_issue_ready); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_bypass_priority();
    pulse_reset();
    @(negedge clk);
    we0 = 1'b1; wa0 = 3'd5; wd0 = 8'h11;
    we1 = 1'b1; wa1 = 3'd5; wd1 = 8'h22;
    ra = {3'd5, 3'd0};
    #1;
    checks++; if (rd[15:8] !== 8'h22) begin errors++; $display("FAIL bypass_same_cycle got %h want 22", rd[15:8]); end
    @(posedge clk);
    #1;
    we0 = 1'b0; we1 = 1'b0;
    #1;
    checks++; if (rd[15:8] !== 8'h22) begin errors++; $display("FAIL priority_stored got %h want 22", rd[15:8]); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_zero_reg();
    pulse_reset();
    @(negedge clk);
    we1 = 1'b1; wa1 = 3'd0; wd1 = 8'hFF;
    issue_valid = 1'b1; issue_wa = 3'd0; ra = 6'd0;
    #1;
    checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL zero_rd_same got %h want 00", rd[7:0]); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", issue_ready); end
    @(posedge clk);
    #1;
    idle();
    #1;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL zero_pending got %h want 00", pending); end
    checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL zero_rd_after got %h want 00", rd[7:0]); end
  endtask

  task automatic test_hazard();
    pulse_reset();
    @(negedge clk);
    issue_valid = 1'b1; issue_wa = 3'd2;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL hz_first got %b want 1", issue_ready); end
    @(posedge clk);
    #1;
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL hz_set got %b want 1", pending[2]); end
    @(negedge clk);
    ra = {3'd0, 3'd2};
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hz_blocked got %b want 0", issue_ready); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL hz_rbusy got %b want 1", rbusy[0]); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 3'd2; wd0 = 8'h5A;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL hz_cleared_ready got %b want 1", issue_ready); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL hz_rbusy_masked got %b want 0", rbusy[0]); end
    checks++; if (rd[7:0] !== 8'h5A) begin errors++; $display("FAIL hz_bypass_rd got %h want 5a", rd[7:0]); end
    @(posedge clk);
    #1;
    we0 = 1'b0; issue_valid = 1'b0;
    #1;
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL hz_reset_by_new got %b want 1", pending[2]); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL hz_rbusy_after got %b want 1", rbusy[0]); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_collision();
    pulse_reset();
    @(negedge clk);
    issue_valid = 1'b1; issue_wa = 3'd4;
    we0 = 1'b1; wa0 = 3'd4; wd0 = 8'h3C;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b want 1", issue_ready); end
    @(posedge clk);
    #1;
    idle();
    ra = {3'd0, 3'd4};
    #1;
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL coll_pending got %h want 10", pending); end
    checks++; if (rd[7:0] !== 8'h3C) begin errors++; $display("FAIL coll_ram got %h want 3c", rd[7:0]); end
  endtask

  task automatic test_random();
    logic held;
    logic exp_ready;
    logic [7:0] e0, e1;
    logic [1:0] eb;
    held = 1'b0;
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      we0 = ($urandom_range(0, 2) == 0);
      we1 = ($urandom_range(0, 2) == 0);
      wa0 = 3'($urandom_range(0, 7));
      wa1 = 3'($urandom_range(0, 7));
      wd0 = 8'($urandom_range(0, 255));
      wd1 = 8'($urandom_range(0, 255));
      ra = 6'($urandom_range(0, 63));
      if (!held) begin
        issue_valid = ($urandom_range(0, 1) == 1);
        issue_wa = 3'($urandom_range(0, 7));
      end
      #1;
      exp_ready = m_ready();
      e0 = m_rd(ra[2:0]);
      e1 = m_rd(ra[5:3]);
      eb = {m_busy(ra[5:3]), m_busy(ra[2:0])};
      checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, issue_ready, exp_ready); end
      checks++; if (rd !== {e1, e0}) begin errors++; $display("FAIL rnd_rd cyc %0d got %h want %h", c, rd, {e1, e0}); end
      checks++; if (rbusy !== eb) begin errors++; $display("FAIL rnd_rbusy cyc %0d got %b want %b", c, rbusy, eb); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending cyc %0d got %h want %h", c, pending, m_pend); end
      @(posedge clk);
      m_edge(exp_ready);
      held = issue_valid && !exp_ready;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_write_nobypass();
    test_bypass_priority();
    test_zero_reg();
    test_hazard();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file with a per-register pending scoreboard. It is the next-generation register file for the processor datapath.
- Provides NREAD combinational read ports and two clocked write ports.
- Optional write-to-read bypass, optional hardwired-zero register 0.
- Asynchronous reset clears the storage.
- The scoreboard tracks registers with an in-flight producer, so decode can detect RAW/WAW hazards and stall.

Parameters:
WIDTH, 8, data width of each register
REGBITS, 3, address width; depth = 2**REGBITS
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = read ports forward same-cycle write data and pending-clear

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ra  input  NREAD*REGBITS  packed read addresses; port i = ra[i*REGBITS +: REGBITS]
rd  output  NREAD*WIDTH  packed read data
rbusy  output  NREAD  port i register pending (hazard)
we0  input  1  write enable, port 0
wa0  input  REGBITS  write address, port 0
wd0  input  WIDTH  write data, port 0
we1  input  1  write enable, port 1 (priority port)
wa1  input  REGBITS  write address, port 1
wd1  input  WIDTH  write data, port 1
issue_valid  input  1  request to mark issue_wa pending
issue_wa  input  REGBITS  destination register of issued instruction
issue_ready  output  1  issue accepted this cycle
pending  output  2**REGBITS  current scoreboard bit vector

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0, pending = 0.
  - Outputs during reset: rd = 0 (or bypassed write data if BYPASS), rbusy = 0, issue_ready = 1 when issue_valid.
  - Reset mid-operation discards all in-flight writes and issues.
- Write: on posedge, we0 writes RAM[wa0] <= wd0 and we1 writes RAM[wa1] <= wd1.
  - we0 and we1 to the same address in one cycle: port 1 wins.
  - ZERO_REG=1 and wa=0: the write is dropped.
- Read: combinational, 0-cycle latency.
  - Port i = 0 when ZERO_REG and ra[i]==0.
  - Else, if BYPASS, forward data from a matching active write (port 1 over port 0).
  - Else RAM[ra[i]].
  - BYPASS=0: the new value is visible the cycle after the edge.
- Scoreboard clear: a write on either port clears pending[wa] at the edge.
- Scoreboard set: an accepted issue sets pending[issue_wa] at the edge.
  - Same address issued and written in one cycle: set wins; the bit stays 1 (new producer).
- issue_ready = issue_valid & ~hazard, where hazard = pending[issue_wa] and not cleared by a write this cycle.
  - The clear-override applies only when BYPASS=1; when BYPASS=0 a pending bit blocks issue until the cycle after its write.
  - ZERO_REG and issue_wa==0: always ready, no bit is set.
  - Rejected issue: no state change; the requester holds issue_valid/issue_wa until accepted.
- rbusy[i] = pending[ra[i]], masked to 0 when:
  - ZERO_REG and ra[i]==0, or
  - BYPASS and a write to ra[i] occurs this cycle.
- No $display or # delays in RTL; all debug printing belongs in the bench.

Decomposition:
- Package regfile_pkg: REGBITS/WIDTH defaults, typedef reg_addr_t, reg_data_t, constant ZERO_ADDR.
- Sub-module regfile_scoreboard (clk, rst_n, set/clear ports, pending, ready logic).
- Storage, read muxes and bypass stay in regfile_sb using generate loops over NREAD.

Test Plan:
- Reset then read: rst_n=0 mid-cycle with RAM holding data -> rd=0 and pending=0 immediately, no clock edge needed.
- Write then read (BYPASS=0): we0, wa0=3, wd0=8'hA5 at edge N -> ra[0]=3 reads 8'hA5 from cycle N+1, 0 before.
- Bypass/priority (BYPASS=1): we0 wa0=5 wd0=8'h11 and we1 wa1=5 wd1=8'h22 in one cycle, ra[1]=5 -> same-cycle rd[1]=8'h22; RAM[5]=8'h22 after the edge.
- Zero register: we1 wa1=0 wd1=8'hFF; issue_wa=0 -> rd=0, pending[0]=0, issue_ready=1.
- Scoreboard hazard: issue_wa=2 accepted at edge N; issue_wa=2 again at N+1 -> issue_ready=0 and rbusy for ra=2 is 1; write wa0=2 at N+2 -> issue accepted that cycle (BYPASS=1), pending[2] remains 1.
- Set/clear collision: issue_wa=4 and we0 wa0=4 in the same cycle with pending[4]=0 -> pending[4]=1 after the edge and RAM[4] updated.
